ex_div_unit: RTL and testbench

//  Multi-cycle 32/32 divider owned by the EX stage. Runs DIV/DIVU as a sequenced

---
 rtl/ex_div_unit_pkg.sv | 19 +
 rtl/ex_div_unit_div_step.sv | 31 +++
 rtl/ex_div_unit.sv | 172 +++++++++++++++++
 tb/tb_ex_div_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg
//   Shared definitions for the EX-stage divider: FSM state encodings, result
//   width and zero constants used when clearing the result path.
package ex_div_unit_pkg;

  localparam int DIV_DATA_W   = 32;
  localparam int DIV_RESULT_W = 2 * DIV_DATA_W;

  localparam logic [DIV_DATA_W-1:0]   ZEROWORD   = '0;
  localparam logic [DIV_RESULT_W-1:0] ZERO_DWORD = '0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// ex_div_unit_div_step
//   One restoring-division step, purely combinational. Shifts the next dividend
//   bit into the partial remainder and subtracts the divisor; the sign of the
//   trial decides the quotient bit and whether the subtraction is kept.
// Ports
//   partial_rem   in   DATA_W  remainder so far (always < divisor)
//   dividend_bit  in   1       next dividend bit, MSB first
//   divisor       in   DATA_W  magnitude of divisor
//   next_rem      out  DATA_W  remainder after this step
//   q_bit         out  1       quotient bit produced by this step
module ex_div_unit_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] partial_rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // partial_rem < divisor keeps shifted < 2*divisor, so a non-negative trial
  // never sets the top bit and the top bit alone is a reliable sign.
  assign shifted  = {partial_rem, dividend_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[DATA_W];
  assign next_rem = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Multi-cycle DIV/DIVU unit for the EX stage: restoring divider producing one
//   quotient bit per cycle on operand magnitudes, with sign fix-up at the end.
//   EX holds start_i until ready_o, stalls on busy_o, and may abort with annul_i.
// Ports
//   clk           in   1         rising-edge clock
//   rst           in   1         synchronous, active-high reset
//   start_i       in   1         division request, held until ready_o
//   annul_i       in   1         abort in-flight division (flush/exception)
//   signed_div_i  in   1         1 = DIV, 0 = DIVU
//   opdata1_i     in   DATA_W    dividend, sampled on accepted start
//   opdata2_i     in   DATA_W    divisor, sampled on accepted start
//   result_o      out  2*DATA_W  {remainder, quotient}
//   ready_o       out  1         result_o valid
//   busy_o        out  1         division in progress
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BYZERO  | divisor was zero, result forced to 0
// DIV_ON      | iterating, one quotient bit per cycle
// DIV_END     | result available, waiting for start_i to drop
import ex_div_unit_pkg::*;

module ex_div_unit #(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_e state;
  div_state_e state_d;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] q_res;
  logic [DATA_W-1:0] r_res;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic [DATA_W-1:0] q_final;

  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  ex_div_unit_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .partial_rem  (rem),
    .dividend_bit (dvd[DATA_W-1]),
    .divisor      (dvs),
    .next_rem     (step_rem),
    .q_bit        (step_q)
  );

  assign q_final = {quo[DATA_W-2:0], step_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        state_d = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt == LAST_STEP) begin
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          state_d = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      q_res    <= '0;
      r_res    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= ZERO_DWORD[2*DATA_W-1:0];
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      // busy stays up through the cycle that enters END so the stall covers
      // every cycle until ready_o is visible.
      busy_o   <= (state_d == DIV_ON) || (state_d == DIV_BYZERO) ||
                  ((state_d == DIV_END) && (state != DIV_END));
      ready_o  <= 1'b0;
      result_o <= ZERO_DWORD[2*DATA_W-1:0];

      case (state)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            dvd   <= op1_abs;
            dvs   <= op2_abs;
            neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r <= signed_div_i && opdata1_i[DATA_W-1];
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
          end
        end
        DIV_BYZERO: begin
          q_res <= ZEROWORD[DATA_W-1:0];
          r_res <= ZEROWORD[DATA_W-1:0];
        end
        DIV_ON: begin
          if (!annul_i) begin
            rem <= step_rem;
            quo <= q_final;
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              q_res <= neg_q ? -q_final : q_final;
              r_res <= neg_r ? -step_rem : step_rem;
            end
          end
        end
        DIV_END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {r_res, q_res};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit
//   Directed bench for ex_div_unit: latency, signed/unsigned results, divide by
//   zero, annul, mid-division reset and start/annul collision in idle.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division from idle; edge index 0 is the accepting edge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input int exp_lat, input string name);
    int lat;
    int busy_cnt;
    logic [63:0] exp_res;
    exp_res = {exp_r, exp_q};
    lat = -1;
    busy_cnt = 0;
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    for (int idx = 0; idx < 60; idx++) begin
      tick();
      if (idx == 0) begin
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0000_0005;
        signed_div_i = ~sgn;
      end
      if (busy_o) busy_cnt++;
      if (ready_o) begin
        lat = idx;
        break;
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result_o, exp_res);
    end
    tick();
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp_res) begin
      errors++;
      $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h",
               name, ready_o, result_o, exp_res);
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s release: ready=%b busy=%b result=%h expected 0/0/0",
               name, ready_o, busy_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    tick();
    tick();
    checks++;
    if (result_o !== 64'h0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h ready=%b busy=%b expected 0/0/0",
               result_o, ready_o, busy_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, "div_7_m2");
  endtask

  task automatic test_overflow();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, "div_min_m1");
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, "divu_min_max");
  endtask

  task automatic test_byzero();
    run_div(1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 2, "divu_by_zero");
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 2, "div_by_zero");
  endtask

  task automatic test_annul();
    int ready_seen;
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int idx = 0; idx <= 10; idx++) tick();
    annul_i = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL annul_abort: busy=%b ready=%b result=%h expected 0/0/0",
               busy_o, ready_o, result_o);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    ready_seen = 0;
    for (int idx = 0; idx < 40; idx++) begin
      tick();
      if (ready_o) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL annul_no_ready: ready cycles got %0d expected 0", ready_seen);
    end
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "restart_9_3");
  endtask

  task automatic test_mid_reset();
    signed_div_i = 1'b1;
    opdata1_i = 32'hFFFF_FF00;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (int idx = 0; idx < 15; idx++) tick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy got %b expected 1", busy_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (result_o !== 64'h0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: result=%h ready=%b busy=%b expected 0/0/0",
               result_o, ready_o, busy_o);
    end
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata2_i = 32'd3;
    for (int idx = 0; idx < 3; idx++) begin
      tick();
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL start_annul_idle[%0d]: busy=%b ready=%b expected 0/0",
                 idx, busy_o, ready_o);
      end
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    run_div(1'b1, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 32'hFFFF_FFFF, 33, "after_reset");
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_byzero();
    test_annul();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
